// File: rtl/alu_seq.sv
// Registered ALU with a valid/ready handshake on both sides.
// MUL is an iterative shift-add over WIDTH cycles. Every other opcode completes in one cycle.
module alu_seq #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_in_valid,
  output logic             o_in_ready,
  input  logic [WIDTH-1:0] i_first_input,
  input  logic [WIDTH-1:0] i_second_input,
  input  logic [3:0]       i_alu_op,
  output logic             o_out_valid,
  input  logic             i_out_ready,
  output logic [WIDTH-1:0] o_output_data,
  output logic             o_zero,
  output logic             o_negative,
  output logic             o_carry,
  output logic             o_overflow,
  output logic             o_illegal_op
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0]    CNT_LAST = CW'(WIDTH - 1);
  localparam logic [WIDTH-1:0] W_LIMIT  = WIDTH'(WIDTH);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_HOLD = 2'd2;

  localparam logic [3:0] OP_ZERO = 4'd0;
  localparam logic [3:0] OP_ADD  = 4'd1;
  localparam logic [3:0] OP_SUB  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_AND  = 4'd4;
  localparam logic [3:0] OP_SHL  = 4'd5;
  localparam logic [3:0] OP_SHR  = 4'd6;
  localparam logic [3:0] OP_XOR  = 4'd7;
  localparam logic [3:0] OP_ASR  = 4'd8;
  localparam logic [3:0] OP_SLT  = 4'd9;
  localparam logic [3:0] OP_SLTU = 4'd10;
  localparam logic [3:0] OP_MUL  = 4'd11;

  logic [1:0]       r_state;
  logic [WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0] r_mplier;
  logic [WIDTH-1:0] r_acc;
  logic [CW-1:0]    r_count;
  logic             r_out_valid;
  logic [WIDTH-1:0] r_data;
  logic             r_zero;
  logic             r_negative;
  logic             r_carry;
  logic             r_overflow;
  logic             r_illegal;

  logic             w_accept;
  logic [WIDTH:0]   w_sum;
  logic [WIDTH-1:0] w_diff;
  logic             w_shamt_big;
  logic [WIDTH-1:0] w_result;
  logic             w_carry;
  logic             w_overflow;
  logic             w_illegal;
  logic [WIDTH-1:0] w_mul_sum;

  // A held result may be replaced on the same edge the consumer takes it.
  assign o_in_ready = (r_state == S_IDLE) || ((r_state == S_HOLD) && i_out_ready);
  assign w_accept   = i_in_valid && o_in_ready;

  assign w_sum       = {1'b0, i_first_input} + {1'b0, i_second_input};
  assign w_diff      = i_first_input - i_second_input;
  assign w_shamt_big = (i_second_input >= W_LIMIT);
  assign w_mul_sum   = r_acc + (r_mplier[0] ? r_mcand : '0);

  always_comb begin
    w_result   = '0;
    w_carry    = 1'b0;
    w_overflow = 1'b0;
    w_illegal  = 1'b0;
    case (i_alu_op)
      OP_ZERO: w_result = '0;
      OP_ADD: begin
        w_result   = w_sum[WIDTH-1:0];
        w_carry    = w_sum[WIDTH];
        w_overflow = (i_first_input[WIDTH-1] == i_second_input[WIDTH-1]) &&
                     (w_sum[WIDTH-1] != i_first_input[WIDTH-1]);
      end
      OP_SUB: begin
        w_result   = w_diff;
        w_carry    = (i_first_input < i_second_input);
        w_overflow = (i_first_input[WIDTH-1] != i_second_input[WIDTH-1]) &&
                     (w_diff[WIDTH-1] != i_first_input[WIDTH-1]);
      end
      OP_OR:   w_result = i_first_input | i_second_input;
      OP_AND:  w_result = i_first_input & i_second_input;
      OP_SHL:  w_result = w_shamt_big ? '0 : (i_first_input << i_second_input);
      OP_SHR:  w_result = w_shamt_big ? '0 : (i_first_input >> i_second_input);
      OP_XOR:  w_result = i_first_input ^ i_second_input;
      OP_ASR:  w_result = w_shamt_big ? {WIDTH{i_first_input[WIDTH-1]}}
                                      : ($signed(i_first_input) >>> i_second_input);
      OP_SLT:  w_result = {{(WIDTH-1){1'b0}}, ($signed(i_first_input) < $signed(i_second_input))};
      OP_SLTU: w_result = {{(WIDTH-1){1'b0}}, (i_first_input < i_second_input)};
      OP_MUL:  w_result = '0;
      default: w_illegal = 1'b1;
    endcase
  end

  // Output registers are cleared on entering BUSY so no partial product is ever visible.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_mcand     <= '0;
      r_mplier    <= '0;
      r_acc       <= '0;
      r_count     <= '0;
      r_out_valid <= 1'b0;
      r_data      <= '0;
      r_zero      <= 1'b0;
      r_negative  <= 1'b0;
      r_carry     <= 1'b0;
      r_overflow  <= 1'b0;
      r_illegal   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_HOLD: begin
          if (w_accept && (i_alu_op == OP_MUL)) begin
            r_state     <= S_BUSY;
            r_mcand     <= i_first_input;
            r_mplier    <= i_second_input;
            r_acc       <= '0;
            r_count     <= '0;
            r_out_valid <= 1'b0;
            r_data      <= '0;
            r_zero      <= 1'b0;
            r_negative  <= 1'b0;
            r_carry     <= 1'b0;
            r_overflow  <= 1'b0;
            r_illegal   <= 1'b0;
          end else if (w_accept) begin
            r_state     <= S_HOLD;
            r_out_valid <= 1'b1;
            r_data      <= w_result;
            r_zero      <= (w_result == '0);
            r_negative  <= w_result[WIDTH-1];
            r_carry     <= w_carry;
            r_overflow  <= w_overflow;
            r_illegal   <= w_illegal;
          end else if ((r_state == S_HOLD) && i_out_ready) begin
            r_state     <= S_IDLE;
            r_out_valid <= 1'b0;
          end
        end
        S_BUSY: begin
          r_acc    <= w_mul_sum;
          r_mcand  <= r_mcand << 1;
          r_mplier <= r_mplier >> 1;
          r_count  <= r_count + CW'(1);
          if (r_count == CNT_LAST) begin
            r_state     <= S_HOLD;
            r_out_valid <= 1'b1;
            r_data      <= w_mul_sum;
            r_zero      <= (w_mul_sum == '0);
            r_negative  <= w_mul_sum[WIDTH-1];
            r_carry     <= 1'b0;
            r_overflow  <= 1'b0;
            r_illegal   <= 1'b0;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_out_valid   = r_out_valid;
  assign o_output_data = r_data;
  assign o_zero        = r_zero;
  assign o_negative    = r_negative;
  assign o_carry       = r_carry;
  assign o_overflow    = r_overflow;
  assign o_illegal_op  = r_illegal;

endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq: expected results are queued when an operation is driven
// and compared when the DUT hands a result to the consumer.
module tb_alu_seq;

  logic        clk;
  logic        rst_n;
  logic        i_in_valid;
  logic        o_in_ready;
  logic [15:0] i_first_input;
  logic [15:0] i_second_input;
  logic [3:0]  i_alu_op;
  logic        o_out_valid;
  logic        i_out_ready;
  logic [15:0] o_output_data;
  logic        o_zero;
  logic        o_negative;
  logic        o_carry;
  logic        o_overflow;
  logic        o_illegal_op;

  logic [20:0] expQ[$];
  int          nCompared;
  int          nMismatched;
  int          cyc;

  alu_seq #(.WIDTH(16)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .i_in_valid     (i_in_valid),
    .o_in_ready     (o_in_ready),
    .i_first_input  (i_first_input),
    .i_second_input (i_second_input),
    .i_alu_op       (i_alu_op),
    .o_out_valid    (o_out_valid),
    .i_out_ready    (i_out_ready),
    .o_output_data  (o_output_data),
    .o_zero         (o_zero),
    .o_negative     (o_negative),
    .o_carry        (o_carry),
    .o_overflow     (o_overflow),
    .o_illegal_op   (o_illegal_op)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    nCompared++;
    if (observed !== expected) begin
      nMismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Packing order: {illegal, overflow, carry, negative, zero, data}
  function automatic logic [20:0] model(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
    logic [15:0] r;
    logic        c;
    logic        v;
    logic        il;
    int          sa;
    int          sb;
    int          s;
    int unsigned ua;
    int unsigned ub;
    r = '0; c = 1'b0; v = 1'b0; il = 1'b0;
    sa = $signed(a); sb = $signed(b); ua = a; ub = b; s = 0;
    case (op)
      4'd1: begin s = sa + sb; r = 16'(ua + ub); c = (ua + ub) > 65535; v = (s > 32767) || (s < -32768); end
      4'd2: begin s = sa - sb; r = 16'(ua - ub); c = ua < ub; v = (s > 32767) || (s < -32768); end
      4'd3: r = a | b;
      4'd4: r = a & b;
      4'd5: r = (ub >= 16) ? 16'h0 : 16'(ua << ub);
      4'd6: r = (ub >= 16) ? 16'h0 : 16'(ua >> ub);
      4'd7: r = a ^ b;
      4'd8: r = (ub >= 16) ? {16{a[15]}} : 16'(sa >>> ub);
      4'd9: r = (sa < sb) ? 16'd1 : 16'd0;
      4'd10: r = (ua < ub) ? 16'd1 : 16'd0;
      4'd11: r = 16'(ua * ub);
      4'd12, 4'd13, 4'd14, 4'd15: il = 1'b1;
      default: r = '0;
    endcase
    return {il, v, c, r[15], (r == 16'h0), r};
  endfunction

  // Consumer side: every handshake pops one expected result.
  always @(negedge clk) begin
    if (rst_n && o_out_valid && i_out_ready) begin
      if (expQ.size() == 0)
        checkOutput("sbUnderflow", 32'(expQ.size()), 32'd1);
      else
        checkOutput("result", {11'h0, o_illegal_op, o_overflow, o_carry, o_negative, o_zero, o_output_data},
                    {11'h0, expQ.pop_front()});
    end
  end

  task automatic applyStimulus(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
    int waitCnt;
    waitCnt = 0;
    i_in_valid     = 1'b1;
    i_alu_op       = op;
    i_first_input  = a;
    i_second_input = b;
    expQ.push_back(model(op, a, b));
    while (!o_in_ready && waitCnt < 100) begin
      @(posedge clk); #1;
      waitCnt++;
    end
    if (waitCnt >= 100) checkOutput("acceptTimeout", 32'(waitCnt), 32'd0);
    @(posedge clk); #1;
    i_in_valid     = 1'b0;
    i_first_input  = 16'hDEAD;
    i_second_input = 16'hBEEF;
    i_alu_op       = 4'd0;
  endtask

  task automatic runMul(input logic [15:0] a, input logic [15:0] b);
    int cycles;
    int readyHigh;
    cycles = 0;
    readyHigh = 0;
    applyStimulus(4'd11, a, b);
    while (!o_out_valid && cycles < 40) begin
      if (o_in_ready) readyHigh++;
      @(posedge clk); #1;
      cycles++;
    end
    checkOutput("mulLatency", 32'(cycles), 32'd16);
    checkOutput("busyInReady", 32'(readyHigh), 32'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    logic [15:0] heldData;
    int          c0;
    int          badHold;
    nCompared = 0; nMismatched = 0; cyc = 0;
    rst_n = 1'b0; i_in_valid = 1'b0; i_out_ready = 1'b1;
    i_first_input = '0; i_second_input = '0; i_alu_op = '0;
    #3;
    checkOutput("resetOutputs", {11'h0, o_illegal_op, o_overflow, o_carry, o_negative, o_zero, o_output_data}, 32'h0);
    checkOutput("resetReady", {30'h0, o_out_valid, o_in_ready}, 32'h1);
    #9 rst_n = 1'b1;
    @(posedge clk); #1;

    applyStimulus(4'd1, 16'h7FFF, 16'h0001);
    checkOutput("addLatency", 32'(o_out_valid), 32'd1);
    applyStimulus(4'd1, 16'hFFFF, 16'h0001);
    applyStimulus(4'd2, 16'd5, 16'd7);
    applyStimulus(4'd9, 16'hFFFF, 16'h0001);
    applyStimulus(4'd10, 16'hFFFF, 16'h0001);
    applyStimulus(4'd13, 16'h1234, 16'h5678);
    applyStimulus(4'd8, 16'h8000, 16'd20);
    applyStimulus(4'd5, 16'h0001, 16'd16);
    applyStimulus(4'd6, 16'h8000, 16'd15);
    applyStimulus(4'd7, 16'hF0F0, 16'hFF00);
    applyStimulus(4'd3, 16'h00F0, 16'h0F0F);
    applyStimulus(4'd4, 16'h0FF0, 16'h3C3C);
    applyStimulus(4'd0, 16'hAAAA, 16'h5555);
    @(posedge clk); #1;

    runMul(16'h0123, 16'h0010);
    runMul(16'hFFFD, 16'h0005);

    // Backpressure: result must sit still while the consumer stalls.
    i_out_ready = 1'b0;
    applyStimulus(4'd1, 16'h1111, 16'h2222);
    heldData = o_output_data;
    i_in_valid = 1'b1; i_alu_op = 4'd2; i_first_input = 16'h0003; i_second_input = 16'h0009;
    expQ.push_back(model(4'd2, 16'h0003, 16'h0009));
    badHold = 0;
    for (int i = 0; i < 5; i++) begin
      if (o_in_ready || !o_out_valid || o_output_data !== heldData) badHold++;
      @(posedge clk); #1;
    end
    checkOutput("holdStable", 32'(badHold), 32'd0);
    checkOutput("holdData", 32'(o_output_data), 32'h3333);
    i_out_ready = 1'b1;
    @(posedge clk); #1;
    i_in_valid = 1'b0;
    checkOutput("sameEdgeAccept", {15'h0, o_out_valid, o_output_data}, {15'h0, 1'b1, 16'hFFFA});

    c0 = cyc;
    applyStimulus(4'd1, 16'd1, 16'd2);
    applyStimulus(4'd1, 16'd100, 16'd200);
    applyStimulus(4'd1, 16'h8000, 16'h8000);
    applyStimulus(4'd1, 16'h4000, 16'h4000);
    checkOutput("throughput", 32'(cyc - c0), 32'd4);
    @(posedge clk); #1;

    // Reset in the middle of a multiply discards it entirely.
    applyStimulus(4'd11, 16'h00FF, 16'h00FF);
    repeat (6) begin @(posedge clk); #1; end
    #2 rst_n = 1'b0;
    expQ.delete();
    #1;
    checkOutput("midMulReset", {11'h0, o_illegal_op, o_overflow, o_carry, o_negative, o_zero, o_output_data}, 32'h0);
    checkOutput("midMulReady", {30'h0, o_out_valid, o_in_ready}, 32'h1);
    #4 rst_n = 1'b1;
    @(posedge clk); #1;
    checkOutput("postResetIdle", {30'h0, o_out_valid, o_in_ready}, 32'h1);
    applyStimulus(4'd1, 16'd2, 16'd3);
    checkOutput("postResetAdd", 32'(o_output_data), 32'h0005);
    repeat (3) begin @(posedge clk); #1; end

    checkOutput("sbDrain", 32'(expQ.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation still running, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
